// File: rtl/pong_pkg.sv
// Shared constants for the PS/2 keyboard front end: scan codes and frame FSM encoding.
package pong_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_Z     = 8'h1A;
  localparam logic [7:0] SC_X     = 8'h22;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  // A PS/2 frame is good when the data byte plus its parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer, run-length glitch filter and falling-edge pulse for one PS/2 line.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_sync,
  output logic o_filt,
  output logic o_fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          r_meta;
  logic          r_sync;
  logic          r_filt;
  logic          r_fall;
  logic [CW-1:0] r_cnt;
  logic          w_flip;

  // r_cnt counts consecutive samples disagreeing with the filtered level.
  assign w_flip = (r_sync != r_filt) && (r_cnt == CW'(FILTER_LEN - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_filt <= 1'b1;
      r_fall <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_fall <= w_flip & r_filt;
      if (r_sync == r_filt) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_filt <= r_sync;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_sync = r_sync;
  assign o_filt = r_filt;
  assign o_fall = r_fall;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard frame receiver and scan-code decoder producing held-key flags for the game loop.
module ps2_key_decoder
  import pong_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic       isEnter,
  output logic       isZ,
  output logic       isX,
  output logic       isLeft,
  output logic       isRight,
  output logic       KeyValid,
  output logic [7:0] KeyCode,
  output logic       FrameErr
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic         w_sample;
  logic         w_data;
  logic         w_clk_sync_unused;
  logic         w_clk_filt_unused;
  logic [1:0]   w_data_unused;

  frame_state_t r_state;
  frame_state_t w_state_next;
  logic         w_accept;
  logic         w_reject;
  logic         w_timeout;

  logic [7:0]    r_shift;
  logic [2:0]    r_bitcnt;
  logic          r_parity;
  logic [TW-1:0] r_timer;
  logic          r_ext;
  logic          r_brk;
  logic          r_enter;
  logic          r_z;
  logic          r_x;
  logic          r_left;
  logic          r_right;
  logic          r_key_valid;
  logic [7:0]    r_keycode;
  logic          r_frame_err;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_line  (PS2Clk),
    .o_sync  (w_clk_sync_unused),
    .o_filt  (w_clk_filt_unused),
    .o_fall  (w_sample)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_line  (PS2Data),
    .o_sync  (w_data),
    .o_filt  (w_data_unused[0]),
    .o_fall  (w_data_unused[1])
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sample && !w_data) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_sample && (r_bitcnt == 3'd7)) w_state_next = ST_PARITY;
      end
      ST_PARITY: begin
        if (w_sample) w_state_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_sample) begin
          w_state_next = ST_IDLE;
          if (odd_parity_ok(r_shift, r_parity) && w_data) w_accept = 1'b1;
          else w_reject = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    // A sample event in the same cycle wins over an expiring timer.
    if ((r_state != ST_IDLE) && !w_sample && (r_timer == TW'(TIMEOUT_CYCLES - 1))) begin
      w_state_next = ST_IDLE;
      w_timeout    = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_parity    <= 1'b0;
      r_timer     <= '0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_enter     <= 1'b0;
      r_z         <= 1'b0;
      r_x         <= 1'b0;
      r_left      <= 1'b0;
      r_right     <= 1'b0;
      r_key_valid <= 1'b0;
      r_keycode   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;

      if ((r_state == ST_IDLE) || w_sample) r_timer <= '0;
      else r_timer <= r_timer + 1'b1;

      if (r_state == ST_IDLE) r_bitcnt <= '0;

      if (w_sample && (r_state == ST_DATA)) begin
        r_shift  <= {w_data, r_shift[7:1]};
        r_bitcnt <= r_bitcnt + 1'b1;
      end
      if (w_sample && (r_state == ST_PARITY)) r_parity <= w_data;

      if (w_reject || w_timeout) begin
        r_frame_err <= 1'b1;
        r_ext       <= 1'b0;
        r_brk       <= 1'b0;
      end else if (w_accept) begin
        if (r_shift == SC_EXT) begin
          r_ext <= 1'b1;
        end else if (r_shift == SC_BRK) begin
          r_brk <= 1'b1;
        end else begin
          r_key_valid <= 1'b1;
          r_keycode   <= r_shift;
          r_ext       <= 1'b0;
          r_brk       <= 1'b0;
          // Non-extended 0x6B/0x74 are keypad keys and must not move the arrows.
          if (r_shift == SC_ENTER)              r_enter <= ~r_brk;
          if ((r_shift == SC_Z) && !r_ext)      r_z     <= ~r_brk;
          if ((r_shift == SC_X) && !r_ext)      r_x     <= ~r_brk;
          if ((r_shift == SC_LEFT) && r_ext)    r_left  <= ~r_brk;
          if ((r_shift == SC_RIGHT) && r_ext)   r_right <= ~r_brk;
        end
      end
    end
  end

  assign isEnter  = r_enter;
  assign isZ      = r_z;
  assign isX      = r_x;
  assign isLeft   = r_left;
  assign isRight  = r_right;
  assign KeyValid = r_key_valid;
  assign KeyCode  = r_keycode;
  assign FrameErr = r_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench: directed scenarios plus random scan-byte traffic against a key-state model.
module tb_ps2_key_decoder;

  localparam int FL   = 4;
  localparam int TO   = 1500;
  localparam int HALF = 10;

  logic       Clock   = 1'b0;
  logic       Reset   = 1'b0;
  logic       PS2Clk  = 1'b1;
  logic       PS2Data = 1'b1;
  logic       isEnter, isZ, isX, isLeft, isRight, KeyValid, FrameErr;
  logic [7:0] KeyCode;

  always #5 Clock = ~Clock;

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .PS2Clk   (PS2Clk),
    .PS2Data  (PS2Data),
    .isEnter  (isEnter),
    .isZ      (isZ),
    .isX      (isX),
    .isLeft   (isLeft),
    .isRight  (isRight),
    .KeyValid (KeyValid),
    .KeyCode  (KeyCode),
    .FrameErr (FrameErr)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;

  // Reference model: index 0..4 = Enter, Z, X, Left, Right.
  bit         m_keys [5];
  bit         m_ext;
  bit         m_brk;
  int         m_kv;
  int         m_fe;
  logic [7:0] m_code;

  always @(negedge Clock) begin
    if (KeyValid) kv_cnt++;
    if (FrameErr) fe_cnt++;
  end

  function automatic int key_index(input logic [7:0] b, input bit ext);
    if (b == 8'h5A) return 0;
    if (b == 8'h1A && !ext) return 1;
    if (b == 8'h22 && !ext) return 2;
    if (b == 8'h6B && ext) return 3;
    if (b == 8'h74 && ext) return 4;
    return -1;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit good);
    int idx;
    if (!good) begin
      m_fe++;
      m_ext = 0;
      m_brk = 0;
      return;
    end
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      idx = key_index(b, m_ext);
      if (idx >= 0) m_keys[idx] = !m_brk;
      m_kv++;
      m_code = b;
      m_ext  = 0;
      m_brk  = 0;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) m_keys[i] = 0;
    m_ext  = 0;
    m_brk  = 0;
    m_code = 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".enter"}, 32'(isEnter), 32'(m_keys[0]));
    chk({tag, ".z"},     32'(isZ),     32'(m_keys[1]));
    chk({tag, ".x"},     32'(isX),     32'(m_keys[2]));
    chk({tag, ".left"},  32'(isLeft),  32'(m_keys[3]));
    chk({tag, ".right"}, 32'(isRight), 32'(m_keys[4]));
    chk({tag, ".kvcnt"}, 32'(kv_cnt),  32'(m_kv));
    chk({tag, ".fecnt"}, 32'(fe_cnt),  32'(m_fe));
    chk({tag, ".code"},  32'(KeyCode), 32'(m_code));
  endtask

  task automatic send_bit(input logic v);
    @(negedge Clock);
    PS2Data = v;
    repeat (HALF - 1) @(negedge Clock);
    PS2Clk = 1'b0;
    repeat (2 * HALF) @(negedge Clock);
    PS2Clk = 1'b1;
    repeat (HALF) @(negedge Clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_err, input bit stop_err, input int nbits);
    logic [10:0] f;
    f[0]    = 1'b0;
    f[8:1]  = b;
    f[9]    = (~^b) ^ par_err;
    f[10]   = ~stop_err;
    $display("tx byte=%02h par_err=%0d stop_err=%0d bits=%0d", b, par_err, stop_err, nbits);
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
    PS2Data = 1'b1;
    repeat (20) @(negedge Clock);
    if (nbits == 11) model_byte(b, !par_err && !stop_err);
  endtask

  task automatic glitch(input int n);
    repeat (n) begin
      @(negedge Clock);
      PS2Clk = 1'b0;
      repeat (FL - 1) @(negedge Clock);
      PS2Clk = 1'b1;
      repeat (FL + 2) @(negedge Clock);
    end
  endtask

  initial begin
    int         base;
    logic [7:0] pool [8];
    logic [7:0] b;
    int         r;
    pool = '{8'hE0, 8'hF0, 8'h5A, 8'h1A, 8'h22, 8'h6B, 8'h74, 8'hE1};
    model_reset();
    m_kv = 0;
    m_fe = 0;

    repeat (5) @(negedge Clock);
    check_all("reset");
    Reset = 1'b1;
    repeat (5) @(negedge Clock);

    // Z press and release
    send_frame(8'h1A, 0, 0, 11);
    check_all("z_make");
    send_frame(8'hF0, 0, 0, 11);
    send_frame(8'h1A, 0, 0, 11);
    check_all("z_break");

    // Extended arrows
    base = kv_cnt;
    send_frame(8'hE0, 0, 0, 11);
    send_frame(8'h6B, 0, 0, 11);
    send_frame(8'hE0, 0, 0, 11);
    send_frame(8'h74, 0, 0, 11);
    check_all("arrows_held");
    chk("arrows_both", 32'({isLeft, isRight}), 32'd3);
    send_frame(8'hE0, 0, 0, 11);
    send_frame(8'hF0, 0, 0, 11);
    send_frame(8'h6B, 0, 0, 11);
    check_all("left_break");
    chk("arrows_kv3", 32'(kv_cnt - base), 32'd3);

    // Keypad 4
    send_frame(8'h6B, 0, 0, 11);
    check_all("keypad4");

    // Bad parity then good X
    base = fe_cnt;
    send_frame(8'h22, 1, 0, 11);
    check_all("bad_parity");
    chk("bad_parity_fe1", 32'(fe_cnt - base), 32'd1);
    send_frame(8'h22, 0, 0, 11);
    check_all("x_make");

    // Stalled frame times out
    send_frame(8'h5A, 0, 0, 5);
    repeat (TO + 200) @(negedge Clock);
    model_byte(8'h00, 0);
    check_all("timeout");
    send_frame(8'h5A, 0, 0, 11);
    check_all("enter_after_timeout");

    // Short clock glitches with data low must not start a frame
    PS2Data = 1'b0;
    glitch(6);
    PS2Data = 1'b1;
    repeat (TO + 200) @(negedge Clock);
    check_all("glitch");

    // Reset mid-frame while Enter is held
    send_frame(8'h1A, 0, 0, 5);
    @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    chk("async_reset.kv", 32'(KeyValid), 32'd0);
    chk("async_reset.fe", 32'(FrameErr), 32'd0);
    repeat (5) @(negedge Clock);
    Reset = 1'b1;
    repeat (5) @(negedge Clock);
    send_frame(8'h22, 0, 0, 11);
    check_all("after_reset");

    // Random scan-byte traffic with occasional corrupted frames
    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 9));
      b = (r == 9) ? 8'($urandom) : pool[$urandom_range(0, 7)];
      r = int'($urandom_range(0, 9));
      send_frame(b, r == 0, r == 1, 11);
      check_all($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
